// File: rtl/host_byte_loader.sv
// Host-side byte loader: MCU strobes bytes into block RAM port B.
// Also sets the auto-incrementing address and reads bytes back.
module host_byte_loader #(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic              sysclk,
   input  logic              external_reset,
   input  logic [DATA_W-1:0] external_data_in,
   input  logic [1:0]        external_data_bank,
   input  logic              external_data_clock,
   input  logic              loader_enable,
   output logic [DATA_W-1:0] host_data_out,
   output logic              loader_busy,
   output logic              loader_overrun,
   output logic              mem_ceb,
   output logic              mem_oceb,
   output logic              mem_wreb,
   output logic [ADDR_W-1:0] mem_adb,
   output logic [DATA_W-1:0] mem_dinb,
   input  logic [DATA_W-1:0] mem_doutb
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WRITE    = 3'd1;
   localparam logic [2:0] S_RD_ISSUE = 3'd2;
   localparam logic [2:0] S_RD_WAIT  = 3'd3;
   localparam logic [2:0] S_RD_CAP   = 3'd4;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]        r_sync;
   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_hdo;
   logic              r_ovr;
   logic              r_ceb;
   logic              r_oceb;
   logic              r_wreb;
   logic [ADDR_W-1:0] r_adb;
   logic [DATA_W-1:0] r_dinb;

   logic              w_edge;
   logic              w_accept;
   logic              w_busy;

   assign w_edge   = r_sync[1] & ~r_sync[2];
   assign w_accept = w_edge & loader_enable;
   assign w_busy   = (r_state != S_IDLE);

   // Two-flop synchronizer on the host strobe plus a third flop for edge detect
   always_ff @(posedge sysclk) begin
      if (external_reset) begin
         r_sync <= 3'b000;
      end else begin
         r_sync <= {r_sync[1:0], external_data_clock};
      end
   end

   // Command FSM: decode the bank on an accepted edge, drive port B, capture reads
   always_ff @(posedge sysclk) begin
      if (external_reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_hdo   <= '0;
         r_ovr   <= 1'b0;
         r_ceb   <= 1'b0;
         r_oceb  <= 1'b0;
         r_wreb  <= 1'b0;
         r_adb   <= '0;
         r_dinb  <= '0;
      end else begin
         r_ceb  <= 1'b0;
         r_oceb <= 1'b0;
         r_wreb <= 1'b0;
         if (w_accept && w_busy) begin
            r_ovr <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (external_data_bank)
                     2'd0: r_addr[7:0] <= external_data_in[7:0];
                     2'd1: r_addr[ADDR_W-1:8] <= external_data_in[ADDR_W-9:0];
                     2'd2: begin
                        r_ceb   <= 1'b1;
                        r_wreb  <= 1'b1;
                        r_adb   <= r_addr;
                        r_dinb  <= external_data_in;
                        r_state <= S_WRITE;
                     end
                     default: begin
                        r_ceb   <= 1'b1;
                        r_oceb  <= 1'b1;
                        r_adb   <= r_addr;
                        r_state <= S_RD_ISSUE;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               r_addr  <= r_addr + ADDR_ONE;
               r_state <= S_IDLE;
            end
            S_RD_ISSUE: begin
               r_state <= (READ_LATENCY == 1) ? S_RD_CAP : S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_state <= S_RD_CAP;
            end
            S_RD_CAP: begin
               r_hdo   <= mem_doutb;
               r_addr  <= r_addr + ADDR_ONE;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign host_data_out  = r_hdo;
   assign loader_busy    = w_busy;
   assign loader_overrun = r_ovr;
   assign mem_ceb        = r_ceb;
   assign mem_oceb       = r_oceb;
   assign mem_wreb       = r_wreb;
   assign mem_adb        = r_adb;
   assign mem_dinb       = r_dinb;

endmodule

// File: tb/tb_host_byte_loader.sv
// Bench for host_byte_loader: RAM model on port B, vector table,
// directed corner sequences and randomized commands against a host model.
module tb_host_byte_loader;

   localparam int RL = 2;

   logic        sysclk = 1'b0;
   logic        external_reset;
   logic [7:0]  external_data_in;
   logic [1:0]  external_data_bank;
   logic        external_data_clock;
   logic        loader_enable;
   logic [7:0]  host_data_out;
   logic        loader_busy;
   logic        loader_overrun;
   logic        mem_ceb;
   logic        mem_oceb;
   logic        mem_wreb;
   logic [12:0] mem_adb;
   logic [7:0]  mem_dinb;
   logic [7:0]  mem_doutb;

   always #5 sysclk = ~sysclk;

   host_byte_loader #(
      .ADDR_W(13),
      .DATA_W(8),
      .READ_LATENCY(RL)
   ) dut (
      .sysclk(sysclk),
      .external_reset(external_reset),
      .external_data_in(external_data_in),
      .external_data_bank(external_data_bank),
      .external_data_clock(external_data_clock),
      .loader_enable(loader_enable),
      .host_data_out(host_data_out),
      .loader_busy(loader_busy),
      .loader_overrun(loader_overrun),
      .mem_ceb(mem_ceb),
      .mem_oceb(mem_oceb),
      .mem_wreb(mem_wreb),
      .mem_adb(mem_adb),
      .mem_dinb(mem_dinb),
      .mem_doutb(mem_doutb)
   );

   // Port B RAM with a two-stage read pipeline, plus a log of every write
   logic [7:0]  ram [8192];
   logic [7:0]  rd1, rd2;
   logic [12:0] wa_q [$];
   logic [7:0]  wd_q [$];

   always @(posedge sysclk) begin
      if (mem_ceb && mem_wreb) begin
         ram[mem_adb] = mem_dinb;
         wa_q.push_back(mem_adb);
         wd_q.push_back(mem_dinb);
      end
      if (mem_ceb && !mem_wreb) rd1 <= ram[mem_adb];
      rd2 <= rd1;
   end
   assign mem_doutb = rd2;

   int checks = 0;
   int errors = 0;

   // Host-level model: address pointer, memory image, last readback
   int         m_addr;
   logic [7:0] m_mem [8192];
   logic [7:0] m_out;

   function automatic void m_apply(input logic [1:0] b, input logic [7:0] d);
      case (b)
         2'd0: m_addr = (m_addr / 256) * 256 + int'(d);
         2'd1: m_addr = (m_addr % 256) + (int'(d) % 32) * 256;
         2'd2: begin
            m_mem[m_addr] = d;
            m_addr = (m_addr + 1) % 8192;
         end
         default: begin
            m_out = m_mem[m_addr];
            m_addr = (m_addr + 1) % 8192;
         end
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".out"},  32'(host_data_out), 0);
      chk({tag, ".busy"}, 32'(loader_busy), 0);
      chk({tag, ".ovr"},  32'(loader_overrun), 0);
      chk({tag, ".ceb"},  32'(mem_ceb), 0);
      chk({tag, ".oceb"}, 32'(mem_oceb), 0);
      chk({tag, ".wreb"}, 32'(mem_wreb), 0);
      chk({tag, ".adb"},  32'(mem_adb), 0);
      chk({tag, ".dinb"}, 32'(mem_dinb), 0);
   endtask

   // One host transaction: data/bank set, strobe pulse, then settle time
   task automatic do_cmd(input logic [1:0] b, input logic [7:0] d,
                         input logic en);
      @(negedge sysclk);
      external_data_bank  = b;
      external_data_in    = d;
      loader_enable       = en;
      @(negedge sysclk);
      external_data_clock = 1'b1;
      repeat (4) @(negedge sysclk);
      external_data_clock = 1'b0;
      repeat (6) @(negedge sysclk);
   endtask

   task automatic exec(input logic [1:0] b, input logic [7:0] d,
                       input logic en, input logic [7:0] eo,
                       input logic [12:0] ea, input logic eovr,
                       input string nm);
      int n0;
      n0 = wa_q.size();
      do_cmd(b, d, en);
      chk({nm, ".out"},  32'(host_data_out), 32'(eo));
      chk({nm, ".ovr"},  32'(loader_overrun), 32'(eovr));
      chk({nm, ".busy"}, 32'(loader_busy), 0);
      if (en && b == 2'd2) begin
         chk({nm, ".nwr"}, wa_q.size(), n0 + 1);
         if (wa_q.size() == n0 + 1) begin
            chk({nm, ".wa"}, 32'(wa_q[n0]), 32'(ea));
            chk({nm, ".wd"}, 32'(wd_q[n0]), 32'(d));
         end
      end else begin
         chk({nm, ".nwr"}, wa_q.size(), n0);
      end
   endtask

   typedef struct {
      logic [1:0]  b;
      logic [7:0]  d;
      logic [7:0]  eo;
      logic [12:0] ea;
   } vec_t;

   vec_t tbl [18];

   initial begin
      logic [7:0]  v;
      logic [7:0]  old_out;
      logic [12:0] exp_adb;
      logic [1:0]  rb;
      logic [7:0]  rdt;
      logic        ren;
      logic [12:0] wa;
      int          n0;

      tbl[0]  = '{b:2'd0, d:8'h34, eo:8'h00, ea:13'h0000};
      tbl[1]  = '{b:2'd1, d:8'h12, eo:8'h00, ea:13'h0000};
      tbl[2]  = '{b:2'd2, d:8'hAA, eo:8'h00, ea:13'h1234};
      tbl[3]  = '{b:2'd2, d:8'hBB, eo:8'h00, ea:13'h1235};
      tbl[4]  = '{b:2'd1, d:8'hFF, eo:8'h00, ea:13'h0000};
      tbl[5]  = '{b:2'd0, d:8'hFF, eo:8'h00, ea:13'h0000};
      tbl[6]  = '{b:2'd2, d:8'h11, eo:8'h00, ea:13'h1FFF};
      tbl[7]  = '{b:2'd2, d:8'h22, eo:8'h00, ea:13'h0000};
      tbl[8]  = '{b:2'd0, d:8'h00, eo:8'h00, ea:13'h0000};
      tbl[9]  = '{b:2'd2, d:8'h55, eo:8'h00, ea:13'h0000};
      tbl[10] = '{b:2'd2, d:8'h66, eo:8'h00, ea:13'h0001};
      tbl[11] = '{b:2'd0, d:8'h00, eo:8'h00, ea:13'h0000};
      tbl[12] = '{b:2'd3, d:8'h00, eo:8'h55, ea:13'h0000};
      tbl[13] = '{b:2'd3, d:8'h00, eo:8'h66, ea:13'h0000};
      tbl[14] = '{b:2'd1, d:8'hFF, eo:8'h66, ea:13'h0000};
      tbl[15] = '{b:2'd0, d:8'hFF, eo:8'h66, ea:13'h0000};
      tbl[16] = '{b:2'd3, d:8'h00, eo:8'h11, ea:13'h0000};
      tbl[17] = '{b:2'd3, d:8'h00, eo:8'h55, ea:13'h0000};

      for (int i = 0; i < 8192; i++) begin
         v = 8'($urandom_range(0, 255));
         ram[i]   = v;
         m_mem[i] = v;
      end
      m_addr = 0;
      m_out  = 8'h00;

      external_reset      = 1'b1;
      external_data_in    = 8'h00;
      external_data_bank  = 2'd0;
      external_data_clock = 1'b0;
      loader_enable       = 1'b1;
      repeat (3) @(negedge sysclk);
      chk_zero("reset");
      external_reset = 1'b0;
      @(negedge sysclk);

      for (int i = 0; i < 18; i++) begin
         m_apply(tbl[i].b, tbl[i].d);
         exec(tbl[i].b, tbl[i].d, 1'b1, tbl[i].eo, tbl[i].ea, 1'b0,
              $sformatf("vec%0d", i));
      end
      chk("ram1234", 32'(ram[13'h1234]), 32'h0AA);
      chk("ram1FFF", 32'(ram[13'h1FFF]), 32'h011);
      chk("model_addr", m_addr, 1);

      // Read latency: edge acted 3 cycles after pin rise, data RL+1 later
      old_out = m_out;
      exp_adb = 13'(m_addr);
      m_apply(2'd3, 8'h00);
      @(negedge sysclk);
      external_data_bank = 2'd3;
      @(negedge sysclk);
      external_data_clock = 1'b1;
      for (int c = 1; c <= RL + 5; c++) begin
         @(negedge sysclk);
         if (c == 2) chk("rt.busy_pre", 32'(loader_busy), 0);
         if (c == 3) begin
            chk("rt.busy_iss", 32'(loader_busy), 1);
            chk("rt.ceb", 32'(mem_ceb), 1);
            chk("rt.oceb", 32'(mem_oceb), 1);
            chk("rt.wreb", 32'(mem_wreb), 0);
            chk("rt.adb", 32'(mem_adb), 32'(exp_adb));
         end
         if (c == 4) begin
            external_data_clock = 1'b0;
            chk("rt.ceb_off", 32'(mem_ceb), 0);
         end
         if (c == RL + 3) begin
            chk("rt.busy_cap", 32'(loader_busy), 1);
            chk("rt.out_hold", 32'(host_data_out), 32'(old_out));
         end
         if (c == RL + 4) begin
            chk("rt.busy_done", 32'(loader_busy), 0);
            chk("rt.out_new", 32'(host_data_out), 32'(m_out));
         end
      end
      repeat (4) @(negedge sysclk);

      // Disabled strobe: no write, pointer untouched
      exec(2'd2, 8'h77, 1'b0, m_out, 13'h0, 1'b0, "dis");
      wa = 13'(m_addr);
      m_apply(2'd2, 8'h78);
      exec(2'd2, 8'h78, 1'b1, m_out, wa, 1'b0, "after_dis");

      // Strobe re-rises during a read: overrun, second command dropped
      n0 = wa_q.size();
      m_apply(2'd3, 8'h00);
      @(negedge sysclk);
      external_data_bank = 2'd3;
      external_data_in   = 8'h00;
      @(negedge sysclk);
      external_data_clock = 1'b1;
      @(negedge sysclk);
      external_data_clock = 1'b0;
      @(negedge sysclk);
      external_data_clock = 1'b1;
      @(negedge sysclk);
      external_data_bank = 2'd2;
      external_data_in   = 8'h99;
      @(negedge sysclk);
      external_data_clock = 1'b0;
      repeat (8) @(negedge sysclk);
      chk("ovr.flag", 32'(loader_overrun), 1);
      chk("ovr.nwr", wa_q.size(), n0);
      chk("ovr.out", 32'(host_data_out), 32'(m_out));
      m_apply(2'd0, 8'h40);
      exec(2'd0, 8'h40, 1'b1, m_out, 13'h0, 1'b1, "ovr_hold");
      m_apply(2'd3, 8'h00);
      exec(2'd3, 8'h00, 1'b1, m_out, 13'h0, 1'b1, "ovr_rd");

      // Reset while waiting on read data: everything clears, no capture
      @(negedge sysclk);
      external_data_bank = 2'd3;
      @(negedge sysclk);
      external_data_clock = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge sysclk);
         if (c == 4) begin
            chk("rw.busy", 32'(loader_busy), 1);
            external_data_clock = 1'b0;
            external_reset      = 1'b1;
         end
         if (c == 5) begin
            chk_zero("rw");
            external_reset = 1'b0;
         end
         if (c == 6 || c == 7) begin
            chk($sformatf("rw.nocap%0d", c), 32'(host_data_out), 0);
            chk($sformatf("rw.idle%0d", c), 32'(loader_busy), 0);
         end
      end
      m_addr = 0;
      m_out  = 8'h00;
      m_apply(2'd3, 8'h00);
      exec(2'd3, 8'h00, 1'b1, m_out, 13'h0, 1'b0, "post_rst_rd");

      // Randomized host commands against the model
      for (int i = 0; i < 60; i++) begin
         rb  = 2'($urandom_range(0, 3));
         rdt = 8'($urandom_range(0, 255));
         ren = ($urandom_range(0, 7) != 0);
         wa  = 13'(m_addr);
         if (ren) m_apply(rb, rdt);
         exec(rb, rdt, ren, m_out, wa, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
